demux_1to3_reg: RTL and testbench

Registered 1-to-3 demultiplexer with a valid/ready handshake on every port, the inverse of the 3-to-1 source selector in the datapath. A single input word stream is steered to one of three destinations, such as the address, word-count and control registers, according to a 2-bit select. Each destination owns a one-word holding register, so a stalled destination blocks only writes aimed at it. The block also keeps a wrapping count of accepted words for status read-back.

---
 rtl/demux_1to3_reg_if.sv | 31 +++
 rtl/demux_1to3_reg.sv | 82 ++++++++
 tb/tb_demux_1to3_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/demux_1to3_reg_if.sv
// Handshake bundle for the registered 1-to-3 demultiplexer: one upstream
// valid/ready port, three downstream valid/ready slots and the accept counter.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

interface demux_1to3_reg_if #(
  parameter int DATA_LENGTH  = `DATA_LENGTH,
  parameter int COUNT_LENGTH = 8
);
  logic [1:0]              sel;
  logic [DATA_LENGTH-1:0]  di;
  logic                    valid_i;
  logic                    ready_o;
  logic [DATA_LENGTH-1:0]  do0;
  logic [DATA_LENGTH-1:0]  do1;
  logic [DATA_LENGTH-1:0]  do2;
  logic [2:0]              valid_o;
  logic [2:0]              ready_i;
  logic [COUNT_LENGTH-1:0] count;

  modport master (
    output sel, di, valid_i, ready_i,
    input  ready_o, do0, do1, do2, valid_o, count
  );

  modport slave (
    input  sel, di, valid_i, ready_i,
    output ready_o, do0, do1, do2, valid_o, count
  );
endinterface

// File: rtl/demux_1to3_reg.sv
// Registered 1-to-3 demultiplexer: steers each accepted word into a per-channel
// one-word holding slot and counts accepted words modulo 2^COUNT_LENGTH.
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

module demux_1to3_reg #(
  parameter int DATA_LENGTH  = `DATA_LENGTH,
  parameter int COUNT_LENGTH = 8
) (
  input logic              clk,
  input logic              reset,
  demux_1to3_reg_if.slave  bus
);

  // Decode order must match the 3-to-1 source selector: sel[1] wins.
  function automatic logic [2:0] decode_sel(input logic [1:0] s);
    logic [2:0] oh;
    case (s)
      2'b00:        oh = 3'b001;
      2'b01:        oh = 3'b010;
      2'b10, 2'b11: oh = 3'b100;
      default:      oh = 3'b000;
    endcase
    return oh;
  endfunction

  logic [2:0]              tgt_oh_s;
  logic                    ready_s;
  logic                    accept_s;
  logic [2:0]              load_s;
  logic [2:0]              valid_r;
  logic [DATA_LENGTH-1:0]  do_r [0:2];
  logic [COUNT_LENGTH-1:0] count_r;

  // Upstream ready looks only at the slot the current select points to.
  always_comb begin
    tgt_oh_s = decode_sel(bus.sel);
    ready_s  = |(tgt_oh_s & (~valid_r | bus.ready_i));
    accept_s = bus.valid_i & ready_s;
    if (accept_s) begin
      load_s = tgt_oh_s;
    end else begin
      load_s = 3'b000;
    end
  end

  // Slot and counter state; a load on a delivering slot keeps valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 3'b000;
      do_r[0] <= {DATA_LENGTH{1'b0}};
      do_r[1] <= {DATA_LENGTH{1'b0}};
      do_r[2] <= {DATA_LENGTH{1'b0}};
      count_r <= {COUNT_LENGTH{1'b0}};
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (load_s[n]) begin
          do_r[n]    <= bus.di;
          valid_r[n] <= 1'b1;
        end else if (bus.ready_i[n]) begin
          valid_r[n] <= 1'b0;
        end else begin
          valid_r[n] <= valid_r[n];
        end
      end
      if (accept_s) begin
        count_r <= count_r + {{(COUNT_LENGTH-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.ready_o = ready_s;
  assign bus.do0     = do_r[0];
  assign bus.do1     = do_r[1];
  assign bus.do2     = do_r[2];
  assign bus.valid_o = valid_r;
  assign bus.count   = count_r;

endmodule

// File: tb/tb_demux_1to3_reg.sv
// Directed and randomized checks for demux_1to3_reg: reset, decode, stall,
// back-to-back, counter wrap and a slot-model scoreboard run.
module tb_demux_1to3_reg;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [7:0] exp_count;

  demux_1to3_reg_if #(.DATA_LENGTH(8), .COUNT_LENGTH(8)) bus ();

  demux_1to3_reg #(.DATA_LENGTH(8), .COUNT_LENGTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [2:0] r);
    bus.valid_i = v;
    bus.sel     = s;
    bus.di      = d;
    bus.ready_i = r;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid got=%b exp=000", bus.valid_o); end
    checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", bus.count); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    step();
    reset = 1'b0;
    drive(1'b1, 2'd0, 8'h10, 3'b000);
    step();
    drive(1'b1, 2'd1, 8'h20, 3'b000);
    step();
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    checks++; if (bus.valid_o !== 3'b011) begin errors++; $display("FAIL prefill_valid got=%b exp=011", bus.valid_o); end
    checks++; if (bus.count !== 8'h02) begin errors++; $display("FAIL prefill_count got=%h exp=02", bus.count); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL midreset_valid got=%b exp=000", bus.valid_o); end
    checks++; if ({bus.do0, bus.do1, bus.do2} !== 24'h000000) begin errors++; $display("FAIL midreset_data got=%h exp=000000", {bus.do0, bus.do1, bus.do2}); end
    checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL midreset_count got=%h exp=00", bus.count); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bus.ready_o); end
    step();
    reset = 1'b0;
    exp_count = 8'h00;
  endtask

  task automatic test_decode();
    logic [7:0] words [0:3];
    words[0] = 8'hA0; words[1] = 8'hA1; words[2] = 8'hA2; words[3] = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), words[i], 3'b111);
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL decode_ready%0d got=%b exp=1", i, bus.ready_o); end
      step();
      exp_count++;
      case (i)
        0: begin checks++; if (bus.do0 !== 8'hA0 || bus.valid_o !== 3'b001) begin errors++; $display("FAIL decode_sel0 do0=%h valid=%b exp=A0/001", bus.do0, bus.valid_o); end end
        1: begin checks++; if (bus.do1 !== 8'hA1 || bus.valid_o !== 3'b010) begin errors++; $display("FAIL decode_sel1 do1=%h valid=%b exp=A1/010", bus.do1, bus.valid_o); end end
        2: begin checks++; if (bus.do2 !== 8'hA2 || bus.valid_o !== 3'b100) begin errors++; $display("FAIL decode_sel2 do2=%h valid=%b exp=A2/100", bus.do2, bus.valid_o); end end
        default: begin checks++; if (bus.do2 !== 8'hA3 || bus.valid_o !== 3'b100) begin errors++; $display("FAIL decode_sel3 do2=%h valid=%b exp=A3/100", bus.do2, bus.valid_o); end end
      endcase
    end
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    checks++; if (bus.count !== 8'h04) begin errors++; $display("FAIL decode_count got=%h exp=04", bus.count); end
    step();
    checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL decode_drain got=%b exp=000", bus.valid_o); end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'd1, 8'h11, 3'b101);
    step();
    exp_count++;
    drive(1'b1, 2'd1, 8'h22, 3'b101);
    checks++; if (bus.do1 !== 8'h11 || bus.valid_o[1] !== 1'b1) begin errors++; $display("FAIL stall_fill do1=%h v1=%b exp=11/1", bus.do1, bus.valid_o[1]); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", bus.ready_o); end
    step();
    step();
    checks++; if (bus.do1 !== 8'h11 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_hold do1=%h ready=%b exp=11/0", bus.do1, bus.ready_o); end
    checks++; if (bus.count !== exp_count) begin errors++; $display("FAIL stall_count got=%h exp=%h", bus.count, exp_count); end
    drive(1'b1, 2'd0, 8'h33, 3'b101);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stall_switch_ready got=%b exp=1", bus.ready_o); end
    step();
    exp_count++;
    checks++; if (bus.do0 !== 8'h33 || bus.valid_o !== 3'b011) begin errors++; $display("FAIL stall_other do0=%h valid=%b exp=33/011", bus.do0, bus.valid_o); end
    drive(1'b1, 2'd1, 8'h22, 3'b111);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", bus.ready_o); end
    step();
    exp_count++;
    checks++; if (bus.do1 !== 8'h22 || bus.valid_o !== 3'b010) begin errors++; $display("FAIL stall_nobubble do1=%h valid=%b exp=22/010", bus.do1, bus.valid_o); end
    checks++; if (bus.count !== exp_count) begin errors++; $display("FAIL stall_count2 got=%h exp=%h", bus.count, exp_count); end
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd0, 8'h77, 3'b000);
    step();
    exp_count++;
    drive(1'b1, 2'd0, 8'h5C, 3'b001);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus.ready_o); end
    step();
    exp_count++;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    checks++; if (bus.valid_o[0] !== 1'b1 || bus.do0 !== 8'h5C) begin errors++; $display("FAIL b2b_slot v0=%b do0=%h exp=1/5C", bus.valid_o[0], bus.do0); end
    checks++; if (bus.count !== exp_count) begin errors++; $display("FAIL b2b_count got=%h exp=%h", bus.count, exp_count); end
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    step();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 2'd0, 8'(i), 3'b111);
      step();
    end
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    checks++; if (bus.count !== 8'hFF) begin errors++; $display("FAIL wrap_255 got=%h exp=FF", bus.count); end
    drive(1'b1, 2'd2, 8'hEE, 3'b111);
    step();
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    checks++; if (bus.count !== 8'h00) begin errors++; $display("FAIL wrap_256 got=%h exp=00", bus.count); end
    drive(1'b1, 2'd1, 8'hEF, 3'b111);
    step();
    drive(1'b0, 2'd0, 8'h00, 3'b111);
    checks++; if (bus.count !== 8'h01) begin errors++; $display("FAIL wrap_257 got=%h exp=01", bus.count); end
  endtask

  task automatic test_random();
    logic [2:0] mvalid;
    logic [7:0] mdata [0:2];
    logic [7:0] mcount;
    logic [7:0] dout [0:2];
    logic       exp_ready;
    int         t;
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    step();
    reset = 1'b0;
    mvalid = 3'b000;
    mcount = 8'h00;
    for (int n = 0; n < 3; n++) mdata[n] = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            3'($urandom_range(0, 7)));
      t = bus.sel[1] ? 2 : (bus.sel[0] ? 1 : 0);
      exp_ready = !mvalid[t] || bus.ready_i[t];
      dout[0] = bus.do0; dout[1] = bus.do1; dout[2] = bus.do2;
      checks++; if (bus.ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.ready_o, exp_ready); end
      checks++; if (bus.valid_o !== mvalid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, bus.valid_o, mvalid); end
      checks++; if (bus.count !== mcount) begin errors++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", c, bus.count, mcount); end
      for (int n = 0; n < 3; n++) begin
        if (mvalid[n]) begin
          checks++; if (dout[n] !== mdata[n]) begin errors++; $display("FAIL rnd_data%0d cyc=%0d got=%h exp=%h", n, c, dout[n], mdata[n]); end
        end
      end
      for (int n = 0; n < 3; n++) begin
        if (bus.valid_i && exp_ready && t == n) begin
          mdata[n]  = bus.di;
          mvalid[n] = 1'b1;
        end else if (bus.ready_i[n]) begin
          mvalid[n] = 1'b0;
        end
      end
      if (bus.valid_i && exp_ready) mcount = mcount + 8'h01;
      step();
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_count = 8'h00;
    test_reset();
    test_decode();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
